// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: two-stage pipelined posit encoder.
// Converts an unpacked posit into a packed WIDTH-bit posit. The unpacked form is sign, biased
// exponent, fraction with guard bits, and sticky. The encoder rounds to nearest even and clamps
// to minpos/maxpos. The output layout is the sign bit followed by the raw remainder, with no
// two's complement.
// Optional feature: define POSIT_ENCODE_SAT_COUNT_EN to add a 16-bit saturating counter of
// clamped beats (port sat_count).
module posit_encode_pipe #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned ES            = 1,
    parameter int unsigned TRAILING_BITS = 2,
    localparam int unsigned MAX_SR       = WIDTH - 2,
    localparam int unsigned EXP_BITS     = $clog2(2 * MAX_SR + 1) + ES,
    localparam int unsigned FRAC_BITS    = WIDTH - 3 - ES,
    localparam int unsigned IN_FRAC_BITS = FRAC_BITS + TRAILING_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic                    in_isZero,
    input  logic                    in_isInf,
    input  logic [EXP_BITS-1:0]     in_exponent,
    input  logic [IN_FRAC_BITS-1:0] in_fraction,
    input  logic                    in_sticky,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_bits
`ifdef POSIT_ENCODE_SAT_COUNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);

    localparam int unsigned UR_BITS   = EXP_BITS - ES;
    localparam int unsigned BODY_BITS = ES + IN_FRAC_BITS;
    // Regime can occupy up to WIDTH bits; zero padding keeps every body bit inside the vector.
    localparam int unsigned FULL_BITS = WIDTH + 1 + BODY_BITS;
    localparam logic [UR_BITS-1:0] MAX_SR_U = UR_BITS'(MAX_SR);
    localparam logic [UR_BITS-1:0] SAT_U    = UR_BITS'(2 * MAX_SR);

    // Handshake
    logic s1Valid, s2Valid, s1Load, s2Load;

    // Stage-1 combinational signals
    logic [UR_BITS-1:0]   uReg;
    logic [BODY_BITS-1:0] body;
    logic                 runBit;
    logic [UR_BITS:0]     runLen;
    logic [FULL_BITS-1:0] seed, runMask, full;

    // Stage-1 registers
    logic             s1Sign, s1Zero, s1Inf, s1Sat, s1Guard, s1Sticky;
    logic [WIDTH-2:0] s1Rem;

    // Stage-2 combinational signals
    logic             roundUp, satHi, satLo;
    logic [WIDTH-1:0] rounded;
    logic [WIDTH-2:0] rem;
    logic [WIDTH-1:0] s2BitsD;

    // Stage-2 registers
    logic [WIDTH-1:0] s2Bits;

    assign s2Load   = !s2Valid || out_ready;
    assign s1Load   = !s1Valid || s2Load;
    assign in_ready = s1Load;

    assign uReg = in_exponent[EXP_BITS-1:ES];

    if (ES > 0) begin : gEsBody
        assign body = {in_exponent[ES-1:0], in_fraction};
    end else begin : gNoEsBody
        assign body = in_fraction;
    end

    // Stage 1: regime run length and the regime/es/fraction bit string
    always_comb begin
        runBit = (uReg >= MAX_SR_U);
        if (runBit) begin
            runLen = {1'b0, uReg} - {1'b0, MAX_SR_U} + (UR_BITS + 1)'(1);
        end else begin
            runLen = {1'b0, MAX_SR_U} - {1'b0, uReg};
        end
        // Terminator and body slide right by the run length; the vacated MSBs carry the run.
        seed    = {~runBit, body, {WIDTH{1'b0}}};
        runMask = ~({FULL_BITS{1'b1}} >> runLen);
        full    = (seed >> runLen) | ({FULL_BITS{runBit}} & runMask);
    end

    // Stage-1 register: truncated remainder plus rounding information
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1Valid  <= 1'b0;
            s1Sign   <= 1'b0;
            s1Zero   <= 1'b0;
            s1Inf    <= 1'b0;
            s1Sat    <= 1'b0;
            s1Guard  <= 1'b0;
            s1Sticky <= 1'b0;
            s1Rem    <= '0;
        end else if (s1Load) begin
            s1Valid  <= in_valid;
            s1Sign   <= in_sign;
            s1Zero   <= in_isZero;
            s1Inf    <= in_isInf;
            s1Sat    <= (uReg > SAT_U);
            s1Rem    <= full[FULL_BITS-1 -: WIDTH-1];
            s1Guard  <= full[BODY_BITS+1];
            s1Sticky <= (|full[BODY_BITS:0]) | in_sticky;
        end
    end

    assign roundUp = s1Guard && (s1Sticky || s1Rem[0]);
    assign rounded = {1'b0, s1Rem} + WIDTH'(roundUp);
    assign satHi   = s1Sat || rounded[WIDTH-1];
    assign satLo   = !satHi && (rounded[WIDTH-2:0] == '0);

    // Stage 2: RNE result, clamping to maxpos/minpos, and special values
    always_comb begin
        rem = rounded[WIDTH-2:0];
        if (satHi) begin
            rem = '1;
        end else if (satLo) begin
            rem = (WIDTH - 1)'(1);
        end
        if (s1Zero) begin
            s2BitsD = '0;
        end else if (s1Inf) begin
            s2BitsD = {1'b1, {(WIDTH - 1){1'b0}}};
        end else begin
            s2BitsD = {s1Sign, rem};
        end
    end

    // Stage-2 register drives the output; holds while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2Valid <= 1'b0;
            s2Bits  <= '0;
        end else if (s2Load) begin
            s2Valid <= s1Valid;
            s2Bits  <= s2BitsD;
        end
    end

    assign out_valid = s2Valid;
    assign out_bits  = s2Bits;

`ifdef POSIT_ENCODE_SAT_COUNT_EN
    logic s2Clamped;
    logic [15:0] satCount;

    // Clamp flag travels with the beat so it is counted when the beat leaves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2Clamped <= 1'b0;
        end else if (s2Load) begin
            s2Clamped <= s1Valid && !s1Zero && !s1Inf && (satHi || satLo);
        end
    end

    // Saturating count of clamped beats handed downstream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            satCount <= '0;
        end else if (s2Valid && out_ready && s2Clamped && (satCount != 16'hFFFF)) begin
            satCount <= satCount + 16'd1;
        end
    end

    assign sat_count = satCount;
`endif

endmodule
